pwm_capture: RTL and testbench

- Receive-side counterpart of the team's PWM generator. Samples an incoming pulse train and measures its period and high time in clk cycles.
- Reports each complete period as a PERIOD/ACTIVE pair with a one-cycle valid strobe.
- Used for generator loopback self-check and for decoding external PWM inputs (fan tach, servo feedback).

---
 rtl/pwm_capture.sv | 158 +++++++++++++++
 tb/tb_pwm_capture.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM period and high-time capture with one-cycle result strobe
module pwm_capture #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] PERIOD,
  output logic [WIDTH-1:0] ACTIVE,
  output logic             valid,
  output logic             overflow,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic                   s_d;
  logic                   rise;
  logic                   fall;

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] hi_cnt;
  logic             cnt_max;

  logic do_result;
  logic do_hi;
  logic do_sat;
  logic do_arm;
  logic load_cnt;
  logic inc_cnt;

  generate
    if (SYNC_STAGES == 1) begin : g_sync1
      // Single-flop synchronizer for pwm_in.
      always_ff @(posedge clk) begin
        if (reset) sync <= '0;
        else       sync <= pwm_in;
      end
    end else begin : g_syncn
      // Multi-flop synchronizer shift chain for pwm_in.
      always_ff @(posedge clk) begin
        if (reset) sync <= '0;
        else       sync <= {sync[SYNC_STAGES-2:0], pwm_in};
      end
    end
  endgenerate

  assign s       = sync[SYNC_STAGES-1];
  assign rise    = s & ~s_d;
  assign fall    = ~s & s_d;
  assign cnt_max = &cnt;
  assign busy    = (state != IDLE);

  // Edge register: previous synchronized level.
  always_ff @(posedge clk) begin
    if (reset) s_d <= 1'b0;
    else       s_d <= s;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and datapath control; stop overrides every other event.
  always_comb begin
    state_nxt = state;
    do_result = 1'b0;
    do_hi     = 1'b0;
    do_sat    = 1'b0;
    do_arm    = 1'b0;
    load_cnt  = 1'b0;
    inc_cnt   = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          state_nxt = ARM;
          do_arm    = 1'b1;
        end
      end
      ARM: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (rise) begin
          state_nxt = HIGH;
          load_cnt  = 1'b1;
        end
      end
      HIGH: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (fall) begin
          state_nxt = LOW;
          do_hi     = 1'b1;
          inc_cnt   = 1'b1;
        end else if (cnt_max) begin
          state_nxt = ARM;
          do_sat    = 1'b1;
        end else begin
          inc_cnt   = 1'b1;
        end
      end
      LOW: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (rise) begin
          state_nxt = HIGH;
          do_result = 1'b1;
          load_cnt  = 1'b1;
        end else if (cnt_max) begin
          state_nxt = ARM;
          do_sat    = 1'b1;
        end else begin
          inc_cnt   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counters, result registers, strobe and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      hi_cnt   <= '0;
      PERIOD   <= '0;
      ACTIVE   <= '0;
      valid    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      valid <= do_result;
      if (load_cnt)     cnt <= WIDTH'(1);
      else if (inc_cnt) cnt <= cnt + WIDTH'(1);
      if (do_hi) hi_cnt <= cnt;
      if (do_result) begin
        PERIOD <= cnt;
        ACTIVE <= hi_cnt;
      end
      if (do_sat)                    overflow <= 1'b1;
      else if (do_result || do_arm)  overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - directed table-driven bench for pwm_capture
module tb_pwm_capture;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         stop;
  logic         pwm_in;
  logic [W-1:0] PERIOD;
  logic [W-1:0] ACTIVE;
  logic         valid;
  logic         overflow;
  logic         busy;

  int tests = 0;
  int fails = 0;

  logic [W-1:0] q_per[$];
  logic [W-1:0] q_act[$];
  logic         q_ovf[$];
  logic         prev_valid = 1'b0;
  int           dbl_valid  = 0;

  typedef struct {
    int hi;
    int lo;
    int reps;
    int per;
    int act;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  pwm_capture #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .pwm_in   (pwm_in),
    .PERIOD   (PERIOD),
    .ACTIVE   (ACTIVE),
    .valid    (valid),
    .overflow (overflow),
    .busy     (busy)
  );

  // Record every result strobe and flag strobes longer than one cycle.
  always @(negedge clk) begin
    if (valid) begin
      q_per.push_back(PERIOD);
      q_act.push_back(ACTIVE);
      q_ovf.push_back(overflow);
    end
    if (valid && prev_valid) dbl_valid++;
    prev_valid = valid;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input int h, input int l);
    pwm_in = 1'b1;
    cyc(h);
    pwm_in = 1'b0;
    cyc(l);
  endtask

  task automatic clear_q();
    q_per.delete();
    q_act.delete();
    q_ovf.delete();
  endtask

  task automatic rearm();
    pwm_in = 1'b0;
    stop   = 1'b1;
    cyc(1);
    stop   = 1'b0;
    cyc(3);
    start  = 1'b1;
    cyc(1);
    start  = 1'b0;
    cyc(4);
  endtask

  task automatic check_results(input string name, input int n, input int per, input int act);
    check({name, "_count"}, q_per.size(), n);
    for (int i = 0; i < q_per.size() && i < n; i++) begin
      check({name, "_period"}, q_per[i], per);
      check({name, "_active"}, q_act[i], act);
      check({name, "_ovf"}, q_ovf[i], 0);
    end
  endtask

  task automatic check_zero(input string name);
    check({name, "_period"}, PERIOD, 0);
    check({name, "_active"}, ACTIVE, 0);
    check({name, "_valid"}, valid, 0);
    check({name, "_overflow"}, overflow, 0);
    check({name, "_busy"}, busy, 0);
  endtask

  initial begin
    vecs[0] = '{1,   1,   4, 2,   1};
    vecs[1] = '{3,   7,   3, 10,  3};
    vecs[2] = '{7,   13,  2, 20,  7};
    vecs[3] = '{2,   1,   3, 3,   2};
    vecs[4] = '{1,   2,   2, 3,   1};
    vecs[5] = '{100, 155, 1, 255, 100};
    vecs[6] = '{6,   4,   2, 10,  6};

    reset = 1'b1; start = 1'b0; stop = 1'b0; pwm_in = 1'b0;
    cyc(3);
    check_zero("reset");
    reset = 1'b0;
    cyc(2);
    check("idle_busy", busy, 0);

    // Table: each vector runs from a fresh arm and ends with a closing rise.
    foreach (vecs[v]) begin
      rearm();
      check("armed_busy", busy, 1);
      clear_q();
      repeat (vecs[v].reps) drive(vecs[v].hi, vecs[v].lo);
      pwm_in = 1'b1;
      cyc(6);
      pwm_in = 1'b0;
      cyc(2);
      check_results($sformatf("vec%0d", v), vecs[v].reps, vecs[v].per, vecs[v].act);
      check("vec_no_ovf", overflow, 0);
    end

    // Pattern change without re-arming.
    rearm();
    clear_q();
    repeat (3) drive(1, 1);
    repeat (2) drive(7, 13);
    pwm_in = 1'b1;
    cyc(6);
    check("switch_count", q_per.size(), 5);
    if (q_per.size() == 5) begin
      check("switch_old_per", q_per[2], 2);
      check("switch_old_act", q_act[2], 1);
      check("switch_new_per", q_per[3], 20);
      check("switch_new_act", q_act[3], 7);
      check("switch_new2_per", q_per[4], 20);
    end

    // Stuck high overflows into ARM, then recovery.
    rearm();
    clear_q();
    pwm_in = 1'b1;
    cyc(200);
    check("ovf_early", overflow, 0);
    cyc(100);
    check("ovf_high_set", overflow, 1);
    check("ovf_high_busy", busy, 1);
    check("ovf_high_novalid", q_per.size(), 0);
    pwm_in = 1'b0;
    cyc(5);
    check("ovf_sticky", overflow, 1);
    clear_q();
    drive(4, 6);
    pwm_in = 1'b1;
    cyc(6);
    pwm_in = 1'b0;
    check_results("ovf_recover", 1, 10, 4);
    check("ovf_cleared", overflow, 0);
    // Stuck low overflows; start accepted in IDLE clears it.
    cyc(300);
    check("ovf_low_set", overflow, 1);
    check("ovf_low_novalid", q_per.size(), 1);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    check("ovf_stop_hold", overflow, 1);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    check("ovf_start_clr", overflow, 0);

    // Stop mid-HIGH keeps the last result.
    rearm();
    clear_q();
    drive(3, 7);
    pwm_in = 1'b1;
    cyc(6);
    check_results("stop_pre", 1, 10, 3);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    check("stop_busy", busy, 0);
    check("stop_per", PERIOD, 10);
    check("stop_act", ACTIVE, 3);
    pwm_in = 1'b0;
    cyc(2);
    repeat (3) drive(2, 2);
    cyc(4);
    check("stop_ignored", q_per.size(), 1);
    check("stop_still_idle", busy, 0);
    check("stop_per_held", PERIOD, 10);

    // start with stop in IDLE: stop wins; start while busy is ignored.
    start = 1'b1; stop = 1'b1;
    cyc(1);
    check("startstop_idle", busy, 0);
    stop = 1'b0;
    cyc(1);
    start = 1'b0;
    check("start_arm", busy, 1);
    cyc(4);
    clear_q();
    drive(5, 5);
    pwm_in = 1'b1;
    cyc(2);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(2);
    pwm_in = 1'b0;
    cyc(5);
    drive(5, 5);
    pwm_in = 1'b1;
    cyc(6);
    check_results("start_busy", 3, 10, 5);

    // Reset during LOW with a result pending.
    pwm_in = 1'b0;
    cyc(5);
    check("rst_pre_busy", busy, 1);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    check_zero("rst_mid");
    clear_q();
    pwm_in = 1'b1;
    cyc(6);
    pwm_in = 1'b0;
    cyc(4);
    drive(2, 2);
    cyc(4);
    check("rst_no_valid", q_per.size(), 0);
    rearm();
    clear_q();
    drive(4, 6);
    pwm_in = 1'b1;
    cyc(6);
    pwm_in = 1'b0;
    check_results("rst_recover", 1, 10, 4);

    check("valid_one_cycle", dbl_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
